// File: rtl/tree_hash_pipe.sv
// Pipelined XOR-fold hash: zero-pads the input to a power-of-two count of OUT_WIDTH chunks,
// folds chunk pairs one register level at a time, then masks the surviving chunk.
module tree_hash_pipe #(
   parameter int IN_WIDTH  = 40,
   parameter int OUT_WIDTH = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 valid_in_RnnH,
   output logic                 ready_out_RnnH,
   input  logic [IN_WIDTH-1:0]  in_RnnH,
   input  logic [OUT_WIDTH-1:0] mask_RnnH,
   output logic                 valid_out_RnnH,
   input  logic                 ready_in_RnnH,
   output logic [OUT_WIDTH-1:0] out_RnnH
);

   localparam int NRAW   = (IN_WIDTH + OUT_WIDTH - 1) / OUT_WIDTH;
   localparam int LEVELS = $clog2(NRAW);
   localparam int NCHUNK = 1 << LEVELS;
   localparam int PADW   = NCHUNK * OUT_WIDTH;

   logic [PADW-1:0]      data_q [LEVELS+1];
   logic [PADW-1:0]      data_d [LEVELS+1];
   logic [OUT_WIDTH-1:0] mask_q [LEVELS+1];
   logic [OUT_WIDTH-1:0] mask_d [LEVELS+1];
   logic [LEVELS:0]      vld_q;
   logic [LEVELS:0]      vld_d;
   logic                 pipe_en;

   // The whole pipe advances together; it only stalls on an unaccepted result.
   assign pipe_en        = ~vld_q[LEVELS] | ready_in_RnnH;
   assign ready_out_RnnH = pipe_en;

   always_comb begin
      data_d[0]                = '0;
      data_d[0][IN_WIDTH-1:0]  = in_RnnH;
      mask_d[0]                = mask_RnnH;
      vld_d[0]                 = valid_in_RnnH & pipe_en;
      for (int k = 1; k <= LEVELS; k++) begin
         data_d[k] = '0;
         // Level k keeps NCHUNK>>k chunks; chunk i pairs with chunk i+N of the level before.
         for (int i = 0; i < NCHUNK / 2; i++) begin
            if (i < (NCHUNK >> k)) begin
               data_d[k][i*OUT_WIDTH +: OUT_WIDTH] =
                  data_q[k-1][i*OUT_WIDTH +: OUT_WIDTH] ^
                  data_q[k-1][(i + (NCHUNK >> k))*OUT_WIDTH +: OUT_WIDTH];
            end
         end
         mask_d[k] = mask_q[k-1];
         vld_d[k]  = vld_q[k-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_q <= '0;
         for (int k = 0; k <= LEVELS; k++) begin
            data_q[k] <= '0;
            mask_q[k] <= '0;
         end
      end else if (pipe_en) begin
         vld_q <= vld_d;
         for (int k = 0; k <= LEVELS; k++) begin
            data_q[k] <= data_d[k];
            mask_q[k] <= mask_d[k];
         end
      end
   end

   assign valid_out_RnnH = vld_q[LEVELS];
   assign out_RnnH       = data_q[LEVELS][OUT_WIDTH-1:0] & mask_q[LEVELS];

endmodule

// File: tb/tb_tree_hash_pipe.sv
// Scoreboard bench for tree_hash_pipe: three instances (40/8, 8/8, 34/4) share clock and reset;
// drivers push expected hashes on accept, negedge monitors pop and compare on each handoff.
module tb_tree_hash_pipe;

   logic clk = 1'b0;
   logic rst;

   logic        vi_a, ro_a, vo_a, ri_a;
   logic [39:0] in_a;
   logic [7:0]  mk_a, out_a;
   logic        vi_b, ro_b, vo_b, ri_b;
   logic [7:0]  in_b, mk_b, out_b;
   logic        vi_c, ro_c, vo_c, ri_c;
   logic [33:0] in_c;
   logic [3:0]  mk_c, out_c;

   logic [7:0] q_a[$];
   logic [7:0] q_b[$];
   logic [3:0] q_c[$];

   int   total = 0;
   int   bad   = 0;
   bit   hold_a = 1'b0;
   logic [7:0] held_a;

   always #5 clk = ~clk;

   tree_hash_pipe #(.IN_WIDTH(40), .OUT_WIDTH(8)) u_a (
      .clk(clk), .rst(rst), .valid_in_RnnH(vi_a), .ready_out_RnnH(ro_a), .in_RnnH(in_a),
      .mask_RnnH(mk_a), .valid_out_RnnH(vo_a), .ready_in_RnnH(ri_a), .out_RnnH(out_a));
   tree_hash_pipe #(.IN_WIDTH(8), .OUT_WIDTH(8)) u_b (
      .clk(clk), .rst(rst), .valid_in_RnnH(vi_b), .ready_out_RnnH(ro_b), .in_RnnH(in_b),
      .mask_RnnH(mk_b), .valid_out_RnnH(vo_b), .ready_in_RnnH(ri_b), .out_RnnH(out_b));
   tree_hash_pipe #(.IN_WIDTH(34), .OUT_WIDTH(4)) u_c (
      .clk(clk), .rst(rst), .valid_in_RnnH(vi_c), .ready_out_RnnH(ro_c), .in_RnnH(in_c),
      .mask_RnnH(mk_c), .valid_out_RnnH(vo_c), .ready_in_RnnH(ri_c), .out_RnnH(out_c));

   // Reference: XOR of every zero-extended chunk, then mask.
   function automatic logic [7:0] fold_ref(input logic [63:0] x, input int ow, input int nch,
                                           input logic [7:0] m);
      logic [63:0] acc;
      acc = '0;
      for (int c = 0; c < nch; c++) acc = acc ^ (x >> (c * ow));
      acc = acc & ((64'd1 << ow) - 64'd1);
      return acc[7:0] & m;
   endfunction

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      total++;
      bad++;
      $display("FAIL %s: bound expired", nm);
   endtask

   // Monitors: compare on every handoff, and require a held result to stay frozen.
   always @(negedge clk) begin
      if (rst) begin
         hold_a = 1'b0;
      end else begin
         if (hold_a) begin
            chk("a_stall_valid", {63'd0, vo_a}, 64'd1);
            chk("a_stall_data", {56'd0, out_a}, {56'd0, held_a});
         end
         hold_a = 1'b0;
         if (vo_a) begin
            if (!ri_a) begin
               hold_a = 1'b1;
               held_a = out_a;
            end else if (q_a.size() == 0) begin
               total++;
               bad++;
               $display("FAIL a_unexpected: got out=%0h with nothing expected", out_a);
            end else begin
               chk("a_out", {56'd0, out_a}, {56'd0, q_a.pop_front()});
            end
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && vo_b && ri_b) begin
         if (q_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL b_unexpected: got out=%0h with nothing expected", out_b);
         end else begin
            chk("b_out", {56'd0, out_b}, {56'd0, q_b.pop_front()});
         end
      end
   end

   always @(negedge clk) begin
      if (!rst && vo_c && ri_c) begin
         if (q_c.size() == 0) begin
            total++;
            bad++;
            $display("FAIL c_unexpected: got out=%0h with nothing expected", out_c);
         end else begin
            chk("c_out", {60'd0, out_c}, {60'd0, q_c.pop_front()});
         end
      end
   end

   task automatic send_a(input logic [39:0] d, input logic [7:0] m, input logic [7:0] exp);
      logic acc;
      int   n;
      vi_a = 1'b1; in_a = d; mk_a = m; acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
         @(negedge clk); acc = ro_a;
         @(posedge clk); #1; n++;
      end
      if (acc) q_a.push_back(exp);
      else fail_now("a_send");
      vi_a = 1'b0;
   endtask

   task automatic send_b(input logic [7:0] d, input logic [7:0] m, input logic [7:0] exp);
      logic acc;
      int   n;
      vi_b = 1'b1; in_b = d; mk_b = m; acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
         @(negedge clk); acc = ro_b;
         @(posedge clk); #1; n++;
      end
      if (acc) q_b.push_back(exp);
      else fail_now("b_send");
      vi_b = 1'b0;
   endtask

   task automatic send_c(input logic [33:0] d, input logic [3:0] m, input logic [3:0] exp);
      logic acc;
      int   n;
      vi_c = 1'b1; in_c = d; mk_c = m; acc = 1'b0; n = 0;
      while (!acc && n < 100) begin
         @(negedge clk); acc = ro_c;
         @(posedge clk); #1; n++;
      end
      if (acc) q_c.push_back(exp);
      else fail_now("c_send");
      vi_c = 1'b0;
   endtask

   // Called just after the accept edge: valid must appear only on the 4th edge counting that one.
   task automatic lat_a(input string nm);
      chk(nm, {63'd0, vo_a}, 64'd0);
      for (int c = 1; c <= 3; c++) begin
         @(posedge clk); #1;
         chk(nm, {63'd0, vo_a}, (c == 3) ? 64'd1 : 64'd0);
      end
   endtask

   task automatic drain;
      int n;
      n = 0;
      while ((q_a.size() != 0 || q_b.size() != 0 || q_c.size() != 0) && n < 300) begin
         @(posedge clk); n++;
      end
      if (n >= 300) fail_now("drain");
      @(posedge clk); #1;
   endtask

   initial begin
      logic [63:0] r;
      logic [7:0]  m8;
      logic [39:0] bp_d [6];
      logic [7:0]  bp_m [6];
      logic [7:0]  bp_e [6];
      bp_d = '{40'h00_00_00_00_AA, 40'h11_22_33_44_55, 40'h80_40_20_10_08,
               40'hFF_FF_FF_FF_FF, 40'h12_34_56_78_9A, 40'h00_00_00_01_00};
      bp_m = '{8'hFF, 8'hFF, 8'hFF, 8'h3C, 8'hF0, 8'hFF};
      bp_e = '{8'hAA, 8'h11, 8'hF8, 8'h3C, 8'h90, 8'h01};

      rst = 1'b1;
      vi_a = 1'b0; in_a = '0; mk_a = '0; ri_a = 1'b1;
      vi_b = 1'b0; in_b = '0; mk_b = '0; ri_b = 1'b1;
      vi_c = 1'b0; in_c = '0; mk_c = '0; ri_c = 1'b1;
      repeat (3) @(posedge clk);
      #4 rst = 1'b0;
      @(posedge clk); #1;
      chk("reset_vo_a", {63'd0, vo_a}, 64'd0);
      chk("reset_out_a", {56'd0, out_a}, 64'd0);
      chk("reset_ro_a", {63'd0, ro_a}, 64'd1);
      chk("reset_vo_b", {63'd0, vo_b}, 64'd0);
      chk("reset_vo_c", {63'd0, vo_c}, 64'd0);
      chk("reset_out_c", {60'd0, out_c}, 64'd0);

      send_a(40'h01_02_04_08_10, 8'hFF, 8'h1F);
      lat_a("basic_latency");
      send_a(40'h01_02_04_08_10, 8'h0F, 8'h0F);
      send_a(40'hFF_00_00_00_FF, 8'hFF, 8'h00);
      drain();

      fork
         for (int i = 0; i < 16; i++) begin
            r  = {$urandom, $urandom};
            m8 = 8'($urandom);
            send_a(r[39:0], m8, fold_ref({24'd0, r[39:0]}, 8, 5, m8));
         end
         begin
            int n, cnt;
            n = 0; cnt = 0;
            while (!vo_a && n < 50) begin @(negedge clk); n++; end
            for (int i = 0; i < 16; i++) begin
               if (vo_a) cnt++;
               @(negedge clk);
            end
            chk("stream_gapless", 64'(cnt), 64'd16);
         end
      join
      drain();

      fork
         for (int i = 0; i < 6; i++) send_a(bp_d[i], bp_m[i], bp_e[i]);
         begin
            int n;
            n = 0;
            do begin @(posedge clk); #1; n++; end while (!vo_a && n < 50);
            ri_a = 1'b0;
            repeat (5) begin
               #1;
               chk("bp_ready_out", {63'd0, ro_a}, 64'd0);
               chk("bp_valid_held", {63'd0, vo_a}, 64'd1);
               @(posedge clk); #1;
            end
            ri_a = 1'b1;
         end
      join
      drain();

      send_a(40'h00_00_00_00_01, 8'hFF, 8'h01);
      send_a(40'h00_00_00_00_02, 8'hFF, 8'h02);
      send_a(40'h00_00_00_00_04, 8'hFF, 8'h04);
      @(posedge clk); #3;
      chk("rst_pre_valid", {63'd0, vo_a}, 64'd1);
      rst = 1'b1;
      q_a.delete();
      #1;
      chk("rst_valid_drop", {63'd0, vo_a}, 64'd0);
      chk("rst_out_clear", {56'd0, out_a}, 64'd0);
      #14 rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         chk("rst_no_stale", {63'd0, vo_a}, 64'd0);
      end
      send_a(40'h0F_00_00_00_F0, 8'hFF, 8'hFF);
      lat_a("rst_new_latency");
      drain();

      send_b(8'hA5, 8'h3C, 8'h24);
      chk("b_latency", {63'd0, vo_b}, 64'd1);
      send_b(8'hFF, 8'h81, 8'h81);
      for (int i = 0; i < 20; i++) begin
         r  = {$urandom, $urandom};
         m8 = 8'($urandom);
         send_b(r[7:0], m8, fold_ref({56'd0, r[7:0]}, 8, 1, m8));
      end
      drain();

      send_c(34'h3_0000_0001, 4'hF, 4'h2);
      chk("c_latency", {63'd0, vo_c}, 64'd0);
      for (int c = 1; c <= 4; c++) begin
         @(posedge clk); #1;
         chk("c_latency", {63'd0, vo_c}, (c == 4) ? 64'd1 : 64'd0);
      end
      send_c(34'h2_1234_5678, 4'hE, 4'hA);
      for (int i = 0; i < 100; i++) begin
         r  = {$urandom, $urandom};
         m8 = {4'd0, 4'($urandom)};
         send_c(r[33:0], m8[3:0], 4'(fold_ref({30'd0, r[33:0]}, 4, 9, m8)));
      end
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
